// File: rtl/cla_seq_adder.sv
// Sequential adder: one 4-bit carry-lookahead slice reused LSB nibble first, WIDTH/4 RUN cycles, done one cycle after the last slice.
// start is ignored while busy; optional subtract port under `CLA_SEQ_SUB_EN.
module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSLICES = WIDTH / 4;
  localparam int IW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic             accept, last;
  logic [WIDTH-1:0] a_q, b_q, b_in;
  logic             carry, c_in;
  logic [IW-1:0]    idx;
  logic [3:0]       a_nib, b_nib, s_nib, g, p;
  logic [4:0]       c;

  // Subtract folds into the add: B is inverted once at capture, initial carry forced to 1.
`ifdef CLA_SEQ_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        last = (idx == LAST);
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NSLICES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  // The shared 4-bit carry-lookahead slice.
  assign g    = a_nib & b_nib;
  assign p    = a_nib ^ b_nib;
  assign c[0] = carry;
  assign c[1] = g[0] | (p[0] & carry);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (&p & carry);
  assign s_nib = p ^ c[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q   <= a;
        b_q   <= b_in;
        carry <= c_in;
        idx   <= '0;
      end else if (busy) begin
        for (int i = 0; i < NSLICES; i++) begin
          if (idx == IW'(i)) sum[4*i +: 4] <= s_nib;
        end
        carry <= c[4];
        idx   <= idx + IW'(1);
        if (last) begin
          cout <= c[4];
          ovf  <= c[3] ^ c[4];
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder (WIDTH=16): vector table plus busy/reset/back-to-back sequences.
`timescale 1ns/1ps
module tb_cla_seq_adder;
  logic        clk = 1'b0;
  logic        rst, start, cin, busy, done, cout, ovf;
  logic [15:0] a, b, sum;
`ifdef CLA_SEQ_SUB_EN
  logic        sub;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef CLA_SEQ_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic accept_op(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, pulses;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum",  sum,  0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf",  ovf,  0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      accept_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(lat, bc);
      chk($sformatf("v%0d_sum", i),  sum,  vecs[i].s);
      chk($sformatf("v%0d_cout", i), cout, vecs[i].co);
      chk($sformatf("v%0d_ovf", i),  ovf,  vecs[i].ov);
      chk($sformatf("v%0d_lat", i),  lat,  4);
      chk($sformatf("v%0d_busy_cycles", i), bc, 4);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // start at E2 of a running add is ignored.
    accept_op(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    chk("ign_sum", sum, 16'h3333);
    chk("ign_lat_rest", lat, 2);
    // start in the done cycle is accepted at the next edge.
    accept_op(16'h0101, 16'h0202, 1'b0);
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    wait_done(lat, bc);
    chk("b2b_sum", sum, 16'h0303);
    chk("b2b_lat", lat, 4);
    @(negedge clk);

    // Reset mid-run discards the operation.
    accept_op(16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum",  sum,  0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("rst_no_done", pulses, 0);
    accept_op(16'h00FF, 16'h0001, 1'b0);
    wait_done(lat, bc);
    chk("post_rst_sum", sum, 16'h0100);
    chk("post_rst_lat", lat, 4);
    @(negedge clk);

    // Simultaneous rst and start: rst wins.
    rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0001;
    @(negedge clk);
    chk("rst_start_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_idle", busy, 0);

`ifdef CLA_SEQ_SUB_EN
    sub = 1'b1;
    accept_op(16'h0005, 16'h0007, 1'b0);
    wait_done(lat, bc);
    chk("sub_5_7_sum",  sum,  16'hFFFE);
    chk("sub_5_7_cout", cout, 0);
    @(negedge clk);
    accept_op(16'h0007, 16'h0005, 1'b1);
    wait_done(lat, bc);
    chk("sub_7_5_sum",  sum,  16'h0002);
    chk("sub_7_5_cout", cout, 1);
    @(negedge clk);
    sub = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
